// File: rtl/page_pkg.sv
// Shared constants and types for the page read-back engine.
package page_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One prefetch buffer slot: the byte plus its end-of-burst flag.
  typedef struct packed {
    logic [DW_DEF-1:0] data;
    logic              last;
  } entry_t;

endpackage

// File: rtl/page_ram.sv
// Simple dual-port page RAM: one write port, one registered read port.
// The read sees the pre-write contents on a same-address collision, and the
// array has no reset, so it maps directly onto a block RAM.
module page_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  // Write port and registered read port share the clock edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/page_reader.sv
// Streams a contiguous (wrapping) address range of the page RAM out as a
// valid/ready byte stream, using a 2-entry prefetch buffer to cover the
// one-cycle RAM read latency.
module page_reader
  import page_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          hw_clk,
  input  logic          hw_rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] len_m1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] rd_left_q, rd_left_d;
  logic          inflight_q, inflight_d;    // RAM read issued last cycle
  logic          infl_last_q, infl_last_d;  // that read is the burst's last byte
  entry_t        fifo_q [2];
  entry_t        fifo_d [2];
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          done_q, done_d;

  logic [DW-1:0] ram_rdata;
  logic          issue, pop, push;
  logic [1:0]    room_used;
  entry_t        head;

  page_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk   (hw_clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (issue),
    .raddr (rd_addr_q),
    .rdata (ram_rdata)
  );

  assign head      = fifo_q[rptr_q];
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head.data;
  assign out_last  = out_valid & head.last;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  // Issue decision: count this cycle's pop as already freeing its slot so a
  // continuously-ready consumer gets one byte per cycle. Occupancy plus
  // in-flight never exceeds 2 after any edge, so the buffer cannot overflow.
  always_comb begin
    pop       = out_valid & out_ready;
    push      = inflight_q;
    room_used = cnt_q - {1'b0, pop} + {1'b0, push};
    issue     = (state_q == RUN) && (room_used < 2'd2);
  end

  // Burst FSM: address/length counters and the final-byte tag on reads.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_left_d   = rd_left_q;
    inflight_d  = issue;
    infl_last_d = issue && (rd_left_q == '0);
    done_d      = pop && head.last;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          rd_addr_d = start_addr;
          rd_left_d = len_m1;
        end
      end
      RUN: begin
        if (issue) begin
          rd_addr_d = rd_addr_q + 1'b1;
          rd_left_d = rd_left_q - 1'b1;
          if (rd_left_q == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Prefetch buffer: RAM output lands the cycle after its read was issued.
  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q ^ push;
    rptr_d = rptr_q ^ pop;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      fifo_d[wptr_q].data = ram_rdata;
      fifo_d[wptr_q].last = infl_last_q;
    end
  end

  // State registers; reset drops the buffer and any read in flight.
  always_ff @(posedge hw_clk) begin
    if (hw_rst) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      rd_left_q   <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      cnt_q       <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_left_q   <= rd_left_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      fifo_q      <= fifo_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: doc/page_reader.md
# page_reader

Read-side engine for the on-chip page parameter store: a 256 x 8 block-RAM page is filled through a simple write port, and this block streams any contiguous address range back out as a valid/ready byte stream. It sits between the page RAM and whatever consumes page contents (serializer, UART dump, LED/IO driver), replacing ad-hoc counter-sequenced read-back. A 2-entry prefetch buffer hides the 1-cycle synchronous RAM read latency and sustains one byte per cycle under backpressure.

## Interface
- AW, 8, address width; page depth is 2**AW.
- DW, 8, data width.
- hw_clk  in  1  single clock; all logic on rising edge.
- hw_rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe to page RAM.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- start  in  1  request a read burst; sampled only in IDLE.
- start_addr  in  AW  first address of burst.
- len_m1  in  AW  burst length minus 1 (0 -> 1 byte, 255 -> 256 bytes).
- out_valid  out  1  out_data holds a valid byte.
- out_ready  in  1  consumer accepts byte when high with out_valid.
- out_data  out  DW  streamed byte.
- out_last  out  1  high with the final byte of the burst.
- busy  out  1  burst in progress (state != IDLE).
- done  out  1  one-cycle pulse after final byte accepted.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 latches rd_addr=start_addr, rd_left=len_m1, go to RUN. start while busy is ignored (no queueing).
- RUN: issue one RAM read per cycle when (buffer occupancy + reads in flight) < 2; each issue increments rd_addr modulo 2**AW (0xFF -> 0x00) and decrements rd_left. When the read with rd_left==0 is issued, go to DRAIN.
- DRAIN: no new reads; when the byte flagged last is handshaken, go to IDLE and pulse done.
- Buffer: 2-entry FIFO of {data, last}; out_valid = FIFO non-empty; out_data/out_last from FIFO head. Entries are never dropped or duplicated; out_data stable while out_valid && !out_ready.
- Writes: accepted every cycle regardless of state. Same-address write and read in one cycle: read returns old data. RAM contents are never cleared by reset.
- Reset (any state, including mid-burst): state IDLE, FIFO emptied, in-flight read discarded, counters 0.
- Reset values: out_valid 0, out_data 0, out_last 0, busy 0, done 0.

## Timing
- Start accepted at edge E0 (IDLE); busy high from E0 on; first RAM read issued at E1; out_valid first high after E2 (latency 2 cycles start->valid).
- With out_ready held high: one byte per cycle, N bytes over N consecutive cycles, out_last on byte N.
- Final handshake at edge Ek: state IDLE, busy 0 and done 1 for the cycle after Ek. A new start sampled in that cycle is accepted.
- out_ready low: reads stall once occupancy+in-flight reaches 2; resume issuing the cycle after a handshake frees a slot.

## Structure
- Package page_pkg: AW/DW default constants, state enum (IDLE, RUN, DRAIN), FIFO entry struct {data, last}.
- Sub-module page_ram: simple dual-port AWxDW RAM, write port + registered synchronous read port, inferable as iCE40 EBR (no read/write check).
- page_reader instantiates page_ram; FIFO and FSM stay inline.

## Test plan
- Reset: assert hw_rst 2 cycles -> out_valid, out_last, busy, done all 0; start during reset ignored.
- Write 0xA1,0xA2,0xA3,0xA4 to 0x10..0x13; start_addr=0x10, len_m1=3, out_ready=1 -> first valid 2 cycles after start, bytes A1..A4 on 4 consecutive cycles, out_last with A4, done pulse next cycle.
- Wrap: write 0xFE=0x11, 0xFF=0x22, 0x00=0x33, 0x01=0x44; start 0xFE len_m1=3 -> 11,22,33,44 in order.
- Backpressure: full page (address i holds i), len_m1=255, out_ready random 50% -> exactly 256 bytes 0x00..0xFF, no loss/duplication, out_last only on 0xFF, data stable while stalled.
- start pulsed mid-burst with different start_addr -> ignored, current burst completes unchanged; start in done cycle -> accepted.
- hw_rst after 5 of 16 bytes -> out_valid 0 next cycle, busy 0, no done; new burst afterwards returns correct, unmodified RAM data.
